// File: rtl/present80_pkg.sv
// Shared definitions for the PRESENT-80 bus front-end: register byte
// addresses, round count and sequencer state encoding.
package present80_pkg;

  localparam int unsigned KEY0_A   = 32'h00;
  localparam int unsigned KEY1_A   = 32'h04;
  localparam int unsigned KEY2_A   = 32'h08;
  localparam int unsigned PT0_A    = 32'h0C;
  localparam int unsigned PT1_A    = 32'h10;
  localparam int unsigned CTRL_A   = 32'h14;
  localparam int unsigned STATUS_A = 32'h18;
  localparam int unsigned CT0_A    = 32'h1C;
  localparam int unsigned CT1_A    = 32'h20;

  // Rounds the cipher core runs between load and ciphertext capture.
  localparam int unsigned ROUNDS = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/present80_seq.sv
// Run sequencer: holds the cipher core in reset while idle and for one load
// cycle, then releases it and counts rounds until the ciphertext is ready.
module present80_seq
  import present80_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic run_q,
  output logic busy,
  output logic capture
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  state_t     state_q;
  state_t     state_d;
  logic [4:0] rnd_q;
  logic [4:0] rnd_d;
  logic       run_d;

  assign busy = (state_q != IDLE);

  // State, round counter and core-release flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic; capture pulses on the last RUN cycle, where the core's
  // combinational output already holds the final ciphertext.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    run_d   = run_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        run_d = 1'b0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        rnd_d   = '0;
        run_d   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (rnd_q == LAST_RND) begin
          capture = 1'b1;
          run_d   = 1'b0;
          state_d = IDLE;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      default: begin
        run_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/present80_mmio.sv
// 32-bit register front-end for the iterative PRESENT-80 core: key/plaintext
// registers, start/status control, ciphertext capture and completion irq.
module present80_mmio
  import present80_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic              core_rstn,
  output logic [79:0]       core_key,
  output logic [63:0]       core_pt,
  input  logic [63:0]       core_ct
);

  logic [79:0] key_q;
  logic [63:0] pt_q;
  logic [63:0] ct_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic [31:0] reg_a;
  logic        run_q;
  logic        busy;
  logic        capture;
  logic        start_req;
  logic        start_acc;
  logic        clr_req;
  logic        wr_ok;
  logic        unused_addr_lsb;

  // Byte offset with the sub-word bits dropped.
  assign reg_a           = 32'({addr[ADDR_W-1:2], 2'b00});
  assign unused_addr_lsb = ^addr[1:0];

  assign wr_ok     = we & ~busy;
  assign start_req = we & (reg_a == CTRL_A) & wdata[0];
  assign start_acc = start_req & ~busy;
  assign clr_req   = we & (reg_a == STATUS_A) & wdata[1];

  present80_seq u_seq (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start_req),
    .run_q   (run_q),
    .busy    (busy),
    .capture (capture)
  );

  // Key and plaintext registers; frozen while a run is in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_q <= '0;
      pt_q  <= '0;
    end else if (wr_ok) begin
      case (reg_a)
        KEY0_A: key_q[31:0]  <= wdata;
        KEY1_A: key_q[63:32] <= wdata;
        KEY2_A: key_q[79:64] <= wdata[15:0];
        PT0_A:  pt_q[31:0]   <= wdata;
        PT1_A:  pt_q[63:32]  <= wdata;
        default: ;
      endcase
    end
  end

  // Ciphertext holds until the next completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ct_q <= '0;
    end else if (capture) begin
      ct_q <= core_ct;
    end
  end

  // Done flag: completion sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= 1'b0;
    end else if (capture) begin
      done_q <= 1'b1;
    end else if (start_acc || clr_req) begin
      done_q <= 1'b0;
    end
  end

  // Read decode from pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (reg_a)
      KEY0_A:   rd_mux = key_q[31:0];
      KEY1_A:   rd_mux = key_q[63:32];
      KEY2_A:   rd_mux = {16'h0000, key_q[79:64]};
      PT0_A:    rd_mux = pt_q[31:0];
      PT1_A:    rd_mux = pt_q[63:32];
      STATUS_A: rd_mux = {30'd0, done_q, busy};
      CT0_A:    rd_mux = ct_q[31:0];
      CT1_A:    rd_mux = ct_q[63:32];
      default:  rd_mux = '0;
    endcase
  end

  // Registered read data, one cycle after re.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rd_mux;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = done_q;
  assign core_rstn = rstn & run_q;
  assign core_key  = key_q;
  assign core_pt   = pt_q;

endmodule

// File: tb/tb_present80_mmio.sv
// Bench for present80_mmio: a behavioural PRESENT-80 core drives core_ct and
// a software encryptor supplies the expected ciphertext for every run.
module tb_present80_mmio;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic        core_rstn;
  logic [79:0] core_key;
  logic [63:0] core_pt;
  logic [63:0] core_ct;

  int checks = 0;
  int errors = 0;
  int pcnt = 0;
  int rises = 0;
  logic irq_d = 1'b0;

  present80_mmio #(.ADDR_W(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .addr      (addr),
    .we        (we),
    .re        (re),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq),
    .core_rstn (core_rstn),
    .core_key  (core_key),
    .core_pt   (core_pt),
    .core_ct   (core_ct)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcnt++;
  always @(negedge clk) begin
    if (irq && !irq_d) rises++;
    irq_d = irq;
  end

  // ---------------- PRESENT-80 primitives ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] slayer(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 16; i++) o[4*i +: 4] = sb(s[4*i +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 63; i++) o[(i * 16) % 63] = s[i];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [79:0] kup(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sb(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  function automatic logic [63:0] present_enc(input logic [79:0] k, input logic [63:0] p);
    logic [63:0] s;
    logic [79:0] kk;
    s  = p;
    kk = k;
    for (int i = 1; i <= 31; i++) begin
      s  = player(slayer(s ^ kk[79:16]));
      kk = kup(kk, 5'(i));
    end
    return s ^ kk[79:16];
  endfunction

  // ---------------- behavioural iterative core ----------------
  // Loads while held in reset; the output shows the next round's result plus
  // the following round key, so it is final after 30 registered rounds.
  logic [63:0] c_st;
  logic [79:0] c_kr;
  logic [4:0]  c_rc;
  logic [79:0] c_knext;

  always @(posedge clk) begin
    if (!core_rstn) begin
      c_st <= core_pt;
      c_kr <= core_key;
      c_rc <= 5'd1;
    end else begin
      c_st <= player(slayer(c_st ^ c_kr[79:16]));
      c_kr <= kup(c_kr, c_rc);
      c_rc <= c_rc + 5'd1;
    end
  end

  always_comb begin
    c_knext = kup(c_kr, c_rc);
    core_ct = player(slayer(c_st ^ c_kr[79:16])) ^ c_knext[79:16];
  end

  // ---------------- checking and bus tasks ----------------
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic wait_edge(input int target);
    int guard = 0;
    while (pcnt < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (pcnt < target) check("wait_timeout", 80'(pcnt), 80'(target));
  endtask

  task automatic load_ops(input logic [79:0] k, input logic [63:0] p);
    wr(6'h00, k[31:0]);
    wr(6'h04, k[63:32]);
    wr(6'h08, {16'h0000, k[79:64]});
    wr(6'h0C, p[31:0]);
    wr(6'h10, p[63:32]);
  endtask

  // mode 0: plain run; 1: KEY0 write while busy; 2: second start during RUN
  task automatic run_vec(input logic [79:0] k, input logic [63:0] p,
                         input logic [63:0] exp, input int mode, input string tag);
    int t0;
    int r0;
    logic [31:0] d0;
    logic [31:0] d1;
    load_ops(k, p);
    wr(6'h14, 32'h1);
    t0 = pcnt;
    r0 = rises;
    if (mode == 1) begin
      wait_edge(t0 + 5);
      wr(6'h00, ~k[31:0]);
      check({tag, "_key_frozen"}, core_key, k);
    end
    if (mode == 2) begin
      wait_edge(t0 + 10);
      wr(6'h14, 32'h1);
      rd(6'h18, d0);
      check({tag, "_status_busy"}, 80'(d0), 80'h1);
    end
    wait_edge(t0 + 31);
    check({tag, "_irq_early"}, 80'(irq), 80'h0);
    wait_edge(t0 + 32);
    check({tag, "_irq_at_32"}, 80'(irq), 80'h1);
    rd(6'h1C, d0);
    rd(6'h20, d1);
    check({tag, "_ct"}, 80'({d1, d0}), 80'(exp));
    rd(6'h18, d0);
    check({tag, "_status_done"}, 80'(d0), 80'h2);
    wait_edge(t0 + 45);
    check({tag, "_single_rise"}, 80'(rises - r0), 80'h1);
    wr(6'h18, 32'h2);
    check({tag, "_irq_cleared"}, 80'(irq), 80'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [79:0] k;
    logic [63:0] p;
    int t0;

    repeat (3) @(negedge clk);
    check("rst_rdata", 80'(rdata), 80'h0);
    check("rst_irq", 80'(irq), 80'h0);
    check("rst_core_rstn", 80'(core_rstn), 80'h0);
    check("rst_core_key", core_key, 80'h0);
    check("rst_core_pt", 80'(core_pt), 80'h0);
    rstn = 1'b1;
    @(negedge clk);

    run_vec(80'h0, 64'h0, 64'h5579C138_7B228445, 0, "v0");
    run_vec({80{1'b1}}, {64{1'b1}}, 64'h3333DCD3_213210D2, 0, "v1");
    run_vec(80'h0, {64{1'b1}}, 64'hA112FFC7_2F68417B, 1, "v2");
    run_vec({80{1'b1}}, 64'h0, 64'hE72C46C0_F5945049, 2, "v3");

    for (int i = 0; i < 4; i++) begin
      k = {16'($urandom), $urandom, $urandom};
      p = {$urandom, $urandom};
      run_vec(k, p, present_enc(k, p), i % 3, "rnd");
    end

    // Reset in the middle of a run.
    k = {16'($urandom), $urandom, $urandom};
    p = {$urandom, $urandom};
    load_ops(k, p);
    wr(6'h14, 32'h1);
    t0 = pcnt;
    wait_edge(t0 + 11);
    rstn = 1'b0;
    #1;
    check("mid_rst_core_rstn", 80'(core_rstn), 80'h0);
    check("mid_rst_irq", 80'(irq), 80'h0);
    check("mid_rst_core_key", core_key, 80'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int a = 0; a <= 8; a++) begin
      rd(6'(a * 4), d);
      check("mid_rst_reg_zero", 80'(d), 80'h0);
    end
    run_vec(k, p, present_enc(k, p), 0, "post_rst");

    // Register-map corner cases.
    wr(6'h08, 32'hFFFF_FFFF);
    rd(6'h08, d);
    check("key2_mask", 80'(d), 80'h0000_FFFF);
    rd(6'h24, d);
    check("unmapped_24", 80'(d), 80'h0);
    for (int i = 0; i < 4; i++) begin
      rd(6'($urandom_range(9, 15) * 4), d);
      check("unmapped_rand", 80'(d), 80'h0);
    end
    rd(6'h14, d);
    check("ctrl_reads_0", 80'(d), 80'h0);

    // Simultaneous read and write return the old value.
    wr(6'h0C, 32'hA5A5_0001);
    @(negedge clk);
    addr = 6'h0C; wdata = 32'h5A5A_0002; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rw_same_cycle_old", 80'(rdata), 80'hA5A5_0001);
    rd(6'h0C, d);
    check("rw_same_cycle_new", 80'(d), 80'h5A5A_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/present80_mmio.md
# present80_mmio

Memory-mapped front-end that lets the RV32I core drive the iterative PRESENT-80 cipher core over a 32-bit register interface. It collects key and plaintext words from bus writes and sequences the cipher core: it loads the core through the core's active-low reset, counts 31 rounds, and captures the ciphertext. It sits between the processor data bus (upstream) and the cipher core (downstream), and raises a level interrupt on completion.

## Interface
Parameters:
- ADDR_W, 6: byte-address width of the register window.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. Asynchronous, active-low. This is the only clock and reset for the block.
- addr  in  ADDR_W  byte address. addr[1:0] is ignored.
- we  in  1  write strobe, single cycle.
- re  in  1  read strobe, single cycle.
- wdata  in  32  write data.
- rdata  out  32  read data. Registered. Valid the cycle after re. Reset value 0.
- irq  out  1  equals the done flag. Reset value 0.
- core_rstn  out  1  drives the cipher core's rstn. Reset value 0.
- core_key  out  80  key presented to the core. Reset value 0.
- core_pt  out  64  plaintext presented to the core. Reset value 0.
- core_ct  in  64  ciphertext output of the core.

## Operation
Register map (word offsets):
- 0x00 KEY0 = key[31:0], RW.
- 0x04 KEY1 = key[63:32], RW.
- 0x08 KEY2 = key[79:64] in bits 15:0, RW. Bits 31:16 read as 0.
- 0x0C PT0 = pt[31:0], RW.
- 0x10 PT1 = pt[63:32], RW.
- 0x14 CTRL: writing bit0 = 1 starts a run. Reads as 0.
- 0x18 STATUS: bit0 = busy, bit1 = done. Writing 1 to bit1 clears done.
- 0x1C CT0 = ct[31:0], RO.
- 0x20 CT1 = ct[63:32], RO.
- Any other address reads 0. Writes to other addresses are ignored.

FSM states and transitions:
- IDLE: core_rstn = 0. Start → LOAD. On start, done is cleared.
- LOAD: one cycle. core_rstn = 0, so the core latches core_key and core_pt. Round counter rnd is set to 0. Next state is RUN.
- RUN: core_rstn = 1. rnd increments every cycle. When rnd == 30, i.e. the 31st RUN cycle, core_ct holds the final ciphertext. That edge captures core_ct into the CT register, sets done, and moves to IDLE.

Signal rules:
- core_rstn = rstn AND run_q, where run_q is a flop. This is glitch-free, and the core is reset whenever the block is reset.
- busy = 1 in LOAD and RUN.
- Writes to KEY* and PT* while busy are ignored.
- A start while busy is ignored.
- core_key and core_pt are the KEY and PT registers, wired directly.
- The CT register holds its value until the next completion.
- rnd is 5 bits wide and never wraps; the FSM leaves RUN at rnd == 30.

Simultaneous events:
- A STATUS done-clear in the same cycle as completion: set wins.
- we and re in the same cycle: both are performed. rdata returns the value from before the write.

Reset mid-run: asynchronous return to IDLE. All registers go to 0, and done = 0.

## Timing
- A start write at edge N puts the FSM in LOAD. RUN lasts edges N+2 … N+32. done and irq are high after edge N+32. Start to done is 32 cycles.
- rdata has a one-cycle read latency. STATUS reflects the state registered at the read edge.
- A start issued in the same cycle that done sets is ignored, because busy is still 1.

## Structure
- Shared package present80_pkg holds:
  - address constants KEY0_A … CT1_A;
  - ROUNDS = 31;
  - the state enum {IDLE, LOAD, RUN}.
- One sub-module, present80_seq: the FSM plus rnd counter. It produces run_q, busy, and capture. The register file and bus decode stay in present80_mmio.
- The cipher core is instantiated one level above, alongside this block.

## Test plan
- Key = 0 and PT = 0, start → after 32 cycles done = 1, irq = 1, CT1:CT0 = 5579C138_7B228445.
- Key = FFFF…FF and PT = FFFF_FFFF_FFFF_FFFF → CT = 3333DCD3_213210D2. Clearing done via a STATUS write drops irq the next cycle.
- Key = 0 and PT = FFFF…FF → CT = A112FFC7_2F68417B. A KEY0 write issued while busy does not change core_key, and the result is unchanged.
- Key = FFFF…FF and PT = 0 → CT = E72C46C0_F5945049. A second start during RUN is ignored; done rises exactly once, at cycle 32.
- Assert rstn at RUN cycle 10 → busy = 0, done = 0, core_rstn = 0, and all registers read 0. A fresh run afterwards completes correctly.
- Read of KEY2 after writing FFFFFFFF → 0000FFFF. Read of address 0x24 → 0. Every read returns one cycle after re.
